// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch (I) and data (D) sides: one access in flight,
// LATENCY+1 cycles of occupancy each; requesters are held off with combinational stalls until done.
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        flush,
  output logic        i_done,
  output logic [15:0] i_rdata,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} stateT;

  localparam logic [2:0] LAT = 3'(LATENCY);

  stateT       state;
  logic [2:0]  cnt;
  logic        lastD;
  logic        squash;
  logic        errQ;
  logic [15:0] iRdataQ;
  logic [15:0] dRdataQ;

  logic complete, canGrant, iPend, dPend, grantI, grantD, errD, errI;

  assign complete = (state != IDLE) && (cnt == 3'd0);
  assign canGrant = (state == IDLE) || complete;

  // The side being served still holds its request in its own completion cycle; never re-grant it.
  assign dPend  = d_req && (state != BUSY_D);
  assign iPend  = i_req && !flush && !((state == BUSY_I) && !squash);
  assign grantI = canGrant && iPend && (!dPend || lastD);
  assign grantD = canGrant && dPend && !grantI;

  assign i_done  = rst && (state == BUSY_I) && complete && !squash;
  assign d_done  = rst && (state == BUSY_D) && complete;
  assign i_rdata = i_done ? mem_rdata : iRdataQ;
  assign d_rdata = (d_done && !mem_wr) ? mem_rdata : dRdataQ;
  assign i_stall = i_req && !i_done;
  assign d_stall = d_req && !d_done;
  assign err     = errQ;

  assign errD = (state == BUSY_D) && !complete && !d_req;
  assign errI = (state == BUSY_I) && !complete && !i_req && !flush && !squash;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      lastD     <= 1'b0;
      squash    <= 1'b0;
      errQ      <= 1'b0;
      iRdataQ   <= 16'h0000;
      dRdataQ   <= 16'h0000;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
    end else begin
      mem_en <= 1'b0;
      if (errD || errI) errQ <= 1'b1;
      if (i_done) iRdataQ <= mem_rdata;
      if (d_done && !mem_wr) dRdataQ <= mem_rdata;
      if ((state == BUSY_I) && flush) squash <= 1'b1;
      if ((state == BUSY_I) && complete) squash <= 1'b0;
      if ((state != IDLE) && !complete) cnt <= cnt - 3'd1;

      if (grantI || grantD) begin
        state     <= grantI ? BUSY_I : BUSY_D;
        cnt       <= LAT;
        lastD     <= grantD;
        mem_en    <= 1'b1;
        mem_wr    <= grantD && d_wr;
        mem_addr  <= grantI ? i_addr : d_addr;
        mem_wdata <= grantD ? d_wdata : 16'h0000;
      end else if (complete) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed-latency memory model, request agents and per-side result scoreboards.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, flush = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_done, i_stall, d_done, d_stall, mem_en, mem_wr, err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .flush(flush),
    .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] memFn(input logic [15:0] a);
    return a ^ 16'hA5B5;
  endfunction

  // Memory returns memFn(addr) exactly LAT cycles after mem_en, garbage otherwise.
  logic [LAT-1:0] vPipe = '0;
  logic [15:0]    dPipe [LAT];
  always @(posedge clk) begin
    cyc++;
    vPipe[0] <= mem_en;
    dPipe[0] <= memFn(mem_addr);
    for (int k = 1; k < LAT; k++) begin
      vPipe[k] <= vPipe[k-1];
      dPipe[k] <= dPipe[k-1];
    end
  end
  assign mem_rdata = vPipe[LAT-1] ? dPipe[LAT-1] : 16'hDEAD;

  typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; } dCmdT;
  typedef struct { logic [15:0] addr; int cyc; } grantT;

  logic [15:0] iCmdQ[$];
  dCmdT        dCmdQ[$];
  logic [15:0] iExpQ[$];
  logic [15:0] dExpQ[$];
  grantT       grantLog[$];
  logic [15:0] iModel = '0;
  logic [15:0] dModel = '0;
  bit autoOn = 0, iDoneSeen = 0, dDoneSeen = 0;

  always @(negedge clk) begin
    if (mem_en) grantLog.push_back('{mem_addr, cyc});
    if (i_done) begin
      iDoneSeen = 1;
      if (iExpQ.size() == 0) check("i_done_unexpected", {31'd0, i_done}, 32'd0);
      else check("i_rdata", {16'd0, i_rdata}, {16'd0, iExpQ.pop_front()});
    end
    if (d_done) begin
      dDoneSeen = 1;
      if (dExpQ.size() == 0) check("d_done_unexpected", {31'd0, d_done}, 32'd0);
      else check("d_rdata", {16'd0, d_rdata}, {16'd0, dExpQ.pop_front()});
    end
  end

  always @(posedge clk) begin
    #1;
    if (autoOn) begin
      if (i_req && iDoneSeen) i_req = 0;
      if (!i_req && iCmdQ.size() != 0) begin
        i_addr = iCmdQ.pop_front();
        i_req  = 1;
        iModel = memFn(i_addr);
        iExpQ.push_back(iModel);
      end
    end
    iDoneSeen = 0;
  end

  always @(posedge clk) begin
    dCmdT c;
    #1;
    if (autoOn) begin
      if (d_req && dDoneSeen) d_req = 0;
      if (!d_req && dCmdQ.size() != 0) begin
        c       = dCmdQ.pop_front();
        d_wr    = c.wr;
        d_addr  = c.addr;
        d_wdata = c.wdata;
        d_req   = 1;
        if (!c.wr) dModel = memFn(c.addr);
        dExpQ.push_back(dModel);
      end
    end
    dDoneSeen = 0;
  end

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic doReset;
    adv; rst = 0; i_req = 0; d_req = 0; d_wr = 0; flush = 0;
    adv; adv; rst = 1;
    iModel = '0; dModel = '0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((iCmdQ.size() != 0 || dCmdQ.size() != 0 || iExpQ.size() != 0 || dExpQ.size() != 0) && n < 200) begin
      smp;
      n++;
    end
    check({tag, "_drain_in_time"}, {31'd0, n < 200}, 32'd1);
    adv; adv;
    autoOn = 0; i_req = 0; d_req = 0; d_wr = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp3 [4];
    exp3 = '{16'h0220, 16'h0060, 16'h0230, 16'h0070};

    // Reset values
    adv; adv; smp;
    check("rst_mem_en", {31'd0, mem_en}, 0);
    check("rst_mem_addr", {16'd0, mem_addr}, 0);
    check("rst_i_done", {31'd0, i_done}, 0);
    check("rst_d_done", {31'd0, d_done}, 0);
    check("rst_i_rdata", {16'd0, i_rdata}, 0);
    check("rst_d_rdata", {16'd0, d_rdata}, 0);
    check("rst_err", {31'd0, err}, 0);
    adv; rst = 1;

    // Single I read: request at t, mem_en at t+1, done at t+1+LAT
    adv; i_req = 1; i_addr = 16'h0010; iModel = 16'hA5A5; iExpQ.push_back(iModel);
    smp;
    check("t1_stall_c1", {31'd0, i_stall}, 1);
    check("t1_en_c1", {31'd0, mem_en}, 0);
    adv; smp;
    check("t1_en_c2", {31'd0, mem_en}, 1);
    check("t1_addr_c2", {16'd0, mem_addr}, 32'h0010);
    check("t1_stall_c2", {31'd0, i_stall}, 1);
    adv; smp;
    check("t1_en_c3", {31'd0, mem_en}, 0);
    check("t1_done_c3", {31'd0, i_done}, 0);
    check("t1_stall_c3", {31'd0, i_stall}, 1);
    adv; smp;
    check("t1_done_c4", {31'd0, i_done}, 1);
    check("t1_stall_c4", {31'd0, i_stall}, 0);
    adv; i_req = 0; smp;
    check("t1_done_c5", {31'd0, i_done}, 0);
    check("t1_hold_c5", {16'd0, i_rdata}, 32'hA5A5);

    // Simultaneous I and D after reset: D first, I granted with no gap
    doReset;
    smp;
    grantLog.delete();
    iCmdQ.push_back(16'h0050);
    dCmdQ.push_back('{1'b0, 16'h0210, 16'h0000});
    autoOn = 1;
    drain("t2");
    check("t2_ngrants", grantLog.size(), 2);
    if (grantLog.size() == 2) begin
      check("t2_first", {16'd0, grantLog[0].addr}, 32'h0210);
      check("t2_second", {16'd0, grantLog[1].addr}, 32'h0050);
      check("t2_gap", grantLog[1].cyc - grantLog[0].cyc, LAT + 1);
    end

    // Continuous requests on both sides alternate D, I, D, I
    smp;
    grantLog.delete();
    dCmdQ.push_back('{1'b0, 16'h0220, 16'h0000});
    dCmdQ.push_back('{1'b1, 16'h0230, 16'h7777});
    iCmdQ.push_back(16'h0060);
    iCmdQ.push_back(16'h0070);
    autoOn = 1;
    drain("t3");
    check("t3_ngrants", grantLog.size(), 4);
    if (grantLog.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t3_order%0d", k), {16'd0, grantLog[k].addr}, {16'd0, exp3[k]});
        if (k > 0) check($sformatf("t3_gap%0d", k), grantLog[k].cyc - grantLog[k-1].cyc, LAT + 1);
      end
    end

    // D write: write qualifiers held for the whole access, load data unchanged
    adv; d_req = 1; d_wr = 1; d_addr = 16'h0200; d_wdata = 16'h1234; dExpQ.push_back(dModel);
    smp;
    check("t4_stall", {31'd0, d_stall}, 1);
    for (int k = 0; k <= LAT; k++) begin
      adv; smp;
      check($sformatf("t4_en%0d", k), {31'd0, mem_en}, {31'd0, k == 0});
      check($sformatf("t4_wr%0d", k), {31'd0, mem_wr}, 1);
      check($sformatf("t4_wdata%0d", k), {16'd0, mem_wdata}, 32'h1234);
      check($sformatf("t4_addr%0d", k), {16'd0, mem_addr}, 32'h0200);
      check($sformatf("t4_done%0d", k), {31'd0, d_done}, {31'd0, k == LAT});
    end
    adv; d_req = 0; d_wr = 0; smp;
    check("t4_rdata_hold", {16'd0, d_rdata}, {16'd0, dModel});

    // Flush during BUSY_I squashes the fetch; pending D granted at completion
    adv; i_req = 1; i_addr = 16'h0030; smp;
    adv; d_req = 1; d_wr = 0; d_addr = 16'h0240; dModel = memFn(16'h0240); dExpQ.push_back(dModel);
    smp;
    check("t5_en_i", {31'd0, mem_en}, 1);
    check("t5_addr_i", {16'd0, mem_addr}, 32'h0030);
    adv; flush = 1; i_req = 0; smp;
    check("t5_nodone_flush", {31'd0, i_done}, 0);
    adv; flush = 0; smp;
    check("t5_nodone_compl", {31'd0, i_done}, 0);
    check("t5_irdata_hold", {16'd0, i_rdata}, {16'd0, iModel});
    check("t5_dstall", {31'd0, d_stall}, 1);
    adv; smp;
    check("t5_en_d", {31'd0, mem_en}, 1);
    check("t5_addr_d", {16'd0, mem_addr}, 32'h0240);
    adv; adv; smp;
    check("t5_d_done", {31'd0, d_done}, 1);
    // Flush in IDLE blocks that cycle's I grant
    adv; d_req = 0; i_req = 1; i_addr = 16'h0080; flush = 1; smp;
    check("t5_idle_en0", {31'd0, mem_en}, 0);
    adv; flush = 0; iModel = memFn(16'h0080); iExpQ.push_back(iModel); smp;
    check("t5_blocked_en", {31'd0, mem_en}, 0);
    adv; smp;
    check("t5_late_en", {31'd0, mem_en}, 1);
    check("t5_late_addr", {16'd0, mem_addr}, 32'h0080);
    adv; adv; smp;
    check("t5_i_done", {31'd0, i_done}, 1);
    adv; i_req = 0; smp;
    check("t5_err_clean", {31'd0, err}, 0);

    // Reset in the middle of BUSY_D drops the access silently
    adv; d_req = 1; d_wr = 0; d_addr = 16'h0250; d_wdata = 16'h5555; smp;
    adv; smp;
    check("t6_en", {31'd0, mem_en}, 1);
    adv; rst = 0; d_req = 0; smp;
    adv; smp;
    check("t6_mem_en", {31'd0, mem_en}, 0);
    check("t6_mem_addr", {16'd0, mem_addr}, 0);
    check("t6_mem_wdata", {16'd0, mem_wdata}, 0);
    check("t6_d_done", {31'd0, d_done}, 0);
    check("t6_d_rdata", {16'd0, d_rdata}, 0);
    check("t6_i_rdata", {16'd0, i_rdata}, 0);
    adv; rst = 1; iModel = '0; dModel = '0;

    // Dropping d_req mid-access raises a sticky error
    adv; d_req = 1; d_wr = 0; d_addr = 16'h0260; dModel = memFn(16'h0260); dExpQ.push_back(dModel); smp;
    adv; smp;
    adv; d_req = 0; smp;
    check("t7_err_before", {31'd0, err}, 0);
    adv; smp;
    check("t7_err_set", {31'd0, err}, 1);
    adv; adv; adv; smp;
    check("t7_err_sticky", {31'd0, err}, 1);
    adv; rst = 0; adv; rst = 1; smp;
    check("t7_err_cleared", {31'd0, err}, 0);

    check("sb_i_empty", iExpQ.size(), 0);
    check("sb_d_empty", dExpQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
